// File: rtl/gray_counter.sv
// ---------------------------------------------------------------------------
// gray_counter
//
// Purpose:
//    Registered up/down binary counter that also presents its count in Gray
//    code. Intended as the pointer source for clock-domain-crossing logic
//    (e.g. async FIFO read/write pointers). Both the binary and Gray outputs
//    come directly from flops. A +/-1 step therefore changes exactly one bit
//    of o_gray and o_gray never glitches, so it can go straight into a
//    multi-flop synchronizer.
//
// Parameters:
//    DATA_WIDTH   counter width in bits (2 or more)
//
// Ports:
//    i_clock        clock, all state updates on the rising edge
//    i_aresetn      asynchronous active-low reset, deassertion sampled by clk
//    i_clear        synchronous clear to zero (highest priority)
//    i_load         synchronous load of i_load_value
//    i_load_value   binary value to load
//    i_en           count enable, one step per cycle while high
//    i_up           direction, 1 = increment, 0 = decrement
//    o_bin          current count, binary, registered
//    o_gray         current count, Gray code, registered
//    o_wrap         one-cycle registered pulse when a count step wrapped
// ---------------------------------------------------------------------------
module gray_counter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clock,
   input  logic                  i_aresetn,
   input  logic                  i_clear,
   input  logic                  i_load,
   input  logic [DATA_WIDTH-1:0] i_load_value,
   input  logic                  i_en,
   input  logic                  i_up,
   output logic [DATA_WIDTH-1:0] o_bin,
   output logic [DATA_WIDTH-1:0] o_gray,
   output logic                  o_wrap
);

   localparam logic [DATA_WIDTH-1:0] C_ZERO = '0;
   localparam logic [DATA_WIDTH-1:0] C_ONE  = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_bin;
   logic [DATA_WIDTH-1:0] r_gray;
   logic                  r_wrap;

   // ------------------------------------------------------------------------
   // Next-state signals
   // ------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] w_bin_inc;
   logic [DATA_WIDTH-1:0] w_bin_dec;
   logic [DATA_WIDTH-1:0] w_bin_next;
   logic [DATA_WIDTH-1:0] w_gray_next;
   logic                  w_wrap_next;
   logic                  w_at_max;
   logic                  w_at_zero;
   logic                  w_step;

   // Modulo arithmetic falls out of the fixed operand width.
   assign w_bin_inc = r_bin + C_ONE;
   assign w_bin_dec = r_bin - C_ONE;

   assign w_at_max  = &r_bin;
   assign w_at_zero = ~|r_bin;

   // A "step" is a plain count: clear and load both suppress it, so neither
   // can raise o_wrap even when they hit the terminal value.
   assign w_step = i_en & ~i_clear & ~i_load;

   // Priority: clear > load > count up > count down > hold.
   always_comb begin
      w_bin_next  = r_bin;
      w_wrap_next = 1'b0;
      if (i_clear) begin
         w_bin_next = C_ZERO;
      end else if (i_load) begin
         w_bin_next = i_load_value;
      end else if (i_en) begin
         if (i_up) begin
            w_bin_next  = w_bin_inc;
            w_wrap_next = w_at_max;
         end else begin
            w_bin_next  = w_bin_dec;
            w_wrap_next = w_at_zero;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Gray encoding of the next binary value. Encoding the next value (rather
   // than the registered one) lets o_gray sit on its own flop with zero
   // latency relative to o_bin and no combinational logic after the flop.
   // ------------------------------------------------------------------------
   assign w_gray_next[DATA_WIDTH-1] = w_bin_next[DATA_WIDTH-1];

   generate
      for (genvar gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_gray_bit
         assign w_gray_next[gi] = w_bin_next[gi] ^ w_bin_next[gi+1];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Registers. Reset clears everything immediately, including a pending
   // wrap pulse. o_wrap is recomputed every edge, so it can only ever be a
   // single-cycle pulse even when i_en is held at the boundary.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clock or negedge i_aresetn) begin
      if (!i_aresetn) begin
         r_bin  <= C_ZERO;
         r_gray <= C_ZERO;
         r_wrap <= 1'b0;
      end else begin
         r_bin  <= w_bin_next;
         r_gray <= w_gray_next;
         r_wrap <= w_wrap_next & w_step;
      end
   end

   assign o_bin  = r_bin;
   assign o_gray = r_gray;
   assign o_wrap = r_wrap;

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Registered up/down binary counter that also presents its count in Gray code.
- Sits directly upstream of the Gray encoding/synchronization path. Typical use: the pointer source for clock-domain-crossing structures such as async FIFO read/write pointers.
- Both outputs come from flops, so o_gray changes exactly one bit per count step and never glitches. It is safe to feed straight into a multi-flop synchronizer.

Parameters:
- DATA_WIDTH, 8, counter width in bits. Legal range is 2 or more.

Ports:
- i_clock  input  1  clock; all state updates on the rising edge.
- i_aresetn  input  1  asynchronous active-low reset. Assertion clears state immediately; deassertion is sampled synchronously to i_clock.
- i_clear  input  1  synchronous clear to zero.
- i_load  input  1  synchronous load of i_load_value.
- i_load_value  input  DATA_WIDTH  binary value to load.
- i_en  input  1  count enable; one step per cycle while high.
- i_up  input  1  direction: 1 = increment, 0 = decrement. Sampled only when counting.
- o_bin  output  DATA_WIDTH  current count, binary, registered.
- o_gray  output  DATA_WIDTH  current count, Gray code, registered.
- o_wrap  output  1  one-cycle pulse, registered, indicating the count wrapped.

Behaviour:
- Reset (i_aresetn low, asynchronous): o_bin = 0, o_gray = 0, o_wrap = 0. Outputs hold these values while reset is held.
- Next binary value (bin_next) is chosen by priority, evaluated each rising edge:
  - i_clear → 0.
  - else i_load → i_load_value.
  - else i_en && i_up → o_bin + 1, modulo 2^DATA_WIDTH.
  - else i_en && !i_up → o_bin − 1, modulo 2^DATA_WIDTH.
  - else hold o_bin.
- Gray encoding:
  - gray_next[i] = bin_next[i] ^ bin_next[i+1] for i < DATA_WIDTH−1.
  - gray_next[MSB] = bin_next[MSB].
  - o_gray is registered from gray_next in the same edge as o_bin.
- Gray invariant: o_gray == gray(o_bin) in every cycle, with zero relative latency.
- Latency: one cycle from an input sampled at edge N to the outputs after edge N.
- Gray step property: a count step (±1) changes exactly one bit of o_gray. Load and clear may change several bits; the user must not load while o_gray is being sampled across domains.
- Wrap conditions (the only cases that set o_wrap = 1 after the edge; otherwise o_wrap = 0):
  - Up-count: o_bin == 2^DATA_WIDTH−1, i_en = 1, i_up = 1, no clear or load.
  - Down-count: o_bin == 0, i_en = 1, i_up = 0, no clear or load.
- o_wrap is a single-cycle pulse. Holding i_en continuously at the boundary produces one pulse per wrap, not a level.
- Simultaneous events:
  - Clear and load together: clear wins.
  - Load and enable together: load wins; no step, o_wrap = 0.
  - Clear or load of the terminal value never produces o_wrap by itself.
- Direction change mid-count takes effect on the next enabled cycle; there is no dead cycle.
- Reset mid-operation forces all outputs to 0 immediately, including any pending o_wrap. Counting resumes from 0 on the first enabled edge after deassertion.
- Contains no combinational path from inputs to outputs.

Test Plan:
- DATA_WIDTH=4: reset, then i_en=1, i_up=1 for 16 cycles.
  - Required: o_bin sequence 0,1,…,15,0.
  - Required: o_gray sequence 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8,0.
  - Required: o_wrap high only in the cycle o_bin returns to 0.
  - Required: exactly one o_gray bit flips per step.
- Down-count from reset, i_up=0, 3 cycles → o_bin 15,14,13 and o_gray 8,9,11; o_wrap pulses in the cycle o_bin = 15.
- i_load=1, i_load_value=9 with i_en=1 → next cycle o_bin=9, o_gray=13, o_wrap=0. Then i_clear=1 together with i_load=1 → o_bin=0, o_gray=0.
- Hold at 15: i_en=0 for 5 cycles (outputs stable 15/8, o_wrap=0), then i_en=1, i_up=1 → o_bin=0 with a single o_wrap pulse.
- At o_bin=7, pulse i_aresetn low asynchronously between edges → outputs go to 0 before the next edge. After release, 2 enabled up-count cycles → o_bin 1,2.
- Random stimulus, 10k cycles, DATA_WIDTH=8 → scoreboard checks:
  - o_gray == gray(o_bin) every cycle.
  - Single-bit Gray change on every pure count step.
  - o_wrap matches the reference model.
